// File: rtl/dcache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_ctrl
// Purpose  : Data-cache line transfer engine. It turns one whole-line fill
//            (RAM -> cache) or one whole-line write-back (cache -> RAM) into
//            a run of per-byte transactions on a byte-wide RAM port. It then
//            reports completion on the cache refill interface.
// Ports    : clkIn/resetIn      - clock, asynchronous active-high reset
//            clearIn            - wrong-branch clear, aborts a line read
//            missIn/missAddrIn/readWriteIn/writeBackIn - cache request
//            memDataValid/memAddrOut/memDataOut/acceptWrite/busy - refill side
//            ramAddr/ramWrite/ramDataOut/ramDataIn - byte-wide RAM port
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem_ctrl #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    clearIn,
  input  logic                    missIn,
  input  logic [31:BLOCK_WIDTH]   missAddrIn,
  input  logic                    readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
  output logic                    memDataValid,
  output logic [31:BLOCK_WIDTH]   memAddrOut,
  output logic [BLOCK_SIZE*8-1:0] memDataOut,
  output logic                    acceptWrite,
  output logic                    busy,
  output logic [31:0]             ramAddr,
  output logic                    ramWrite,
  output logic [7:0]              ramDataOut,
  input  logic [7:0]              ramDataIn
);

  localparam int               CNT_W   = BLOCK_WIDTH + 1;
  // A read spends one extra cycle collecting the last byte.
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q,     state_d;
  logic [CNT_W-1:0]          cnt_q,       cnt_d;
  logic [31:BLOCK_WIDTH]     base_q,      base_d;
  logic [BLOCK_SIZE*8-1:0]   wdata_q,     wdata_d;
  logic [BLOCK_SIZE*8-1:0]   line_q,      line_d;
  logic                      valid_q,     valid_d;
  logic                      accept_q,    accept_d;
  logic                      busy_q,      busy_d;
  logic [31:BLOCK_WIDTH]     mem_addr_q,  mem_addr_d;
  logic [BLOCK_SIZE*8-1:0]   mem_data_q,  mem_data_d;
  logic [31:0]               ram_addr_q,  ram_addr_d;
  logic                      ram_write_q, ram_write_d;
  logic [7:0]                ram_data_q,  ram_data_d;
  logic [BLOCK_WIDTH-1:0]    rd_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    line_d      = line_q;
    valid_d     = 1'b0;
    accept_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    ram_addr_d  = ram_addr_q;
    ram_write_d = 1'b0;
    ram_data_d  = ram_data_q;
    // RAM data lags its address by one cycle, so the byte arriving now
    // belongs to the previous count (wraps to the last byte at RD_LAST).
    rd_idx      = cnt_q[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);

    case (state_q)
      IDLE: begin
        // A clear on the request edge kills a read, never a write-back.
        if (missIn && !(clearIn && readWriteIn)) begin
          base_d  = missAddrIn;
          wdata_d = writeBackIn;
          cnt_d   = '0;
          state_d = readWriteIn ? READ : WRITE;
        end
      end
      READ: begin
        if (clearIn) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != '0) begin
            line_d[{rd_idx, 3'b000} +: 8] = ramDataIn;
          end
          if (cnt_q == RD_LAST) begin
            state_d    = DONE;
            valid_d    = 1'b1;
            mem_addr_d = base_q;
            mem_data_d = line_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d    = DONE;
          accept_d   = 1'b1;
          mem_addr_d = base_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // DONE: the cache updates its line this cycle, so missIn is ignored.
        state_d = IDLE;
      end
    endcase

    // RAM port outputs are registered and follow the state being entered.
    case (state_d)
      READ: begin
        if (cnt_d != RD_LAST) begin
          ram_addr_d = {base_d, cnt_d[BLOCK_WIDTH-1:0]};
        end
      end
      WRITE: begin
        ram_write_d = 1'b1;
        ram_addr_d  = {base_d, cnt_d[BLOCK_WIDTH-1:0]};
        ram_data_d  = wdata_d[{cnt_d[BLOCK_WIDTH-1:0], 3'b000} +: 8];
      end
      default: begin
        ram_addr_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      valid_q     <= 1'b0;
      accept_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      ram_addr_q  <= '0;
      ram_write_q <= 1'b0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      line_q      <= line_d;
      valid_q     <= valid_d;
      accept_q    <= accept_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_write_q <= ram_write_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign memDataValid = valid_q;
  assign acceptWrite  = accept_q;
  assign busy         = busy_q;
  assign memAddrOut   = mem_addr_q;
  assign memDataOut   = mem_data_q;
  assign ramAddr      = ram_addr_q;
  assign ramWrite     = ram_write_q;
  assign ramDataOut   = ram_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dcache_mem_ctrl
// Purpose  : Self-checking bench for dcache_mem_ctrl. It applies a table of
//            line transfers plus hand-written reset, clear and back-to-back
//            sequences. The RAM model returns byte = addr[7:0] one cycle
//            after the address is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_ctrl;

  localparam int BW = 4;

  logic         clkIn = 1'b0;
  logic         resetIn, clearIn, missIn, readWriteIn;
  logic [31:BW] missAddrIn;
  logic [127:0] writeBackIn;
  logic         memDataValid, acceptWrite, busy, ramWrite;
  logic [31:BW] memAddrOut;
  logic [127:0] memDataOut;
  logic [31:0]  ramAddr;
  logic [7:0]   ramDataOut, ramDataIn;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_mem_ctrl #(.BLOCK_WIDTH(BW)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .missIn(missIn),
    .missAddrIn(missAddrIn), .readWriteIn(readWriteIn), .writeBackIn(writeBackIn),
    .memDataValid(memDataValid), .memAddrOut(memAddrOut), .memDataOut(memDataOut),
    .acceptWrite(acceptWrite), .busy(busy), .ramAddr(ramAddr), .ramWrite(ramWrite),
    .ramDataOut(ramDataOut), .ramDataIn(ramDataIn)
  );

  always #5 clkIn = ~clkIn;

  // Byte-wide RAM: data for an address appears the cycle after it.
  always @(posedge clkIn) ramDataIn <= ramAddr[7:0];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rw;
    logic [27:0]  line;
    logic [127:0] wdata;
    int           clear_at;   // cnt value at which clearIn is raised, -1 = never
    logic [127:0] exp_data;   // memDataOut after the transfer
    logic [27:0]  exp_addr;   // memAddrOut after the transfer
  } vec_t;

  vec_t vecs[7];

  // One table transfer; samples on falling edges, sample k is cycle cnt=k-1.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat, busy_end, ram_end;
    logic [31:0] exp_ra;
    logic        pulse;
    lat      = v.rw ? 18 : 17;
    busy_end = v.rw ? ((v.clear_at >= 0) ? v.clear_at + 1 : 18) : 17;
    ram_end  = v.rw ? ((v.clear_at >= 0) ? v.clear_at + 1 : 17) : 16;
    @(negedge clkIn);
    missIn = 1'b1; readWriteIn = v.rw; missAddrIn = v.line; writeBackIn = v.wdata;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clkIn);
      if (k == 1) begin
        // Inputs are sampled only at acceptance; scramble them afterwards.
        missIn = 1'b0; missAddrIn = ~v.line; writeBackIn = ~v.wdata; readWriteIn = ~v.rw;
      end
      pulse = (k == lat) && !(v.rw && v.clear_at >= 0);
      check($sformatf("v%0d k%0d memDataValid", idx, k), memDataValid, v.rw & pulse);
      check($sformatf("v%0d k%0d acceptWrite", idx, k), acceptWrite, !v.rw & pulse);
      check($sformatf("v%0d k%0d busy", idx, k), busy, k <= busy_end);
      check($sformatf("v%0d k%0d ramWrite", idx, k), ramWrite, !v.rw && k <= 16);
      if (k <= ram_end) begin
        exp_ra = (k == 17) ? {v.line, 4'hF} : {v.line, 4'(k - 1)};
        check($sformatf("v%0d k%0d ramAddr", idx, k), ramAddr, exp_ra);
        if (!v.rw)
          check($sformatf("v%0d k%0d ramDataOut", idx, k), ramDataOut, v.wdata[8*(k-1) +: 8]);
      end
      if (pulse) begin
        check($sformatf("v%0d pulse memAddrOut", idx), memAddrOut, v.line);
        check($sformatf("v%0d pulse memDataOut", idx), memDataOut, v.exp_data);
      end
      clearIn = (k == v.clear_at + 1);
    end
    clearIn = 1'b0;
    check($sformatf("v%0d end memDataOut", idx), memDataOut, v.exp_data);
    check($sformatf("v%0d end memAddrOut", idx), memAddrOut, v.exp_addr);
  endtask

  initial begin
    int pulses;
    logic [127:0] fill12, fill55, fillff, wb34, wbx;
    fill12 = 128'h2F2E2D2C2B2A29282726252423222120;
    fill55 = 128'h5F5E5D5C5B5A59585756555453525150;
    fillff = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
    wb34   = 128'h0F0E0D0C0B0A09080706050403020100;
    wbx    = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

    vecs[0] = '{1'b1, 28'h0000012, '0,   -1, fill12, 28'h0000012};
    vecs[1] = '{1'b0, 28'h0000034, wb34, -1, fill12, 28'h0000034};
    vecs[2] = '{1'b1, 28'h0000012, '0,    7, fill12, 28'h0000034};
    vecs[3] = '{1'b1, 28'h0000055, '0,   -1, fill55, 28'h0000055};
    vecs[4] = '{1'b0, 28'h0ABCDEF, wbx,   3, fill55, 28'h0ABCDEF};
    vecs[5] = '{1'b1, 28'h0777777, '0,   16, fill55, 28'h0ABCDEF};
    vecs[6] = '{1'b1, 28'hFFFFFFF, '0,   -1, fillff, 28'hFFFFFFF};

    resetIn = 1'b1; clearIn = 1'b0; missIn = 1'b0; readWriteIn = 1'b0;
    missAddrIn = '0; writeBackIn = '0;
    repeat (2) @(negedge clkIn);
    check("rst memDataValid", memDataValid, 0);
    check("rst acceptWrite", acceptWrite, 0);
    check("rst busy", busy, 0);
    check("rst ramWrite", ramWrite, 0);
    check("rst ramAddr", ramAddr, 0);
    check("rst ramDataOut", ramDataOut, 0);
    check("rst memAddrOut", memAddrOut, 0);
    check("rst memDataOut", memDataOut, 0);
    resetIn = 1'b0;

    // Reset in the middle of a write-back at cnt=5.
    @(negedge clkIn);
    missIn = 1'b1; readWriteIn = 1'b0; missAddrIn = 28'h0000034; writeBackIn = wb34;
    @(negedge clkIn);
    missIn = 1'b0;
    repeat (5) @(negedge clkIn);
    check("midwr ramAddr cnt5", ramAddr, 32'h345);
    resetIn = 1'b1;
    #1;
    check("midwr rst ramWrite", ramWrite, 0);
    check("midwr rst busy", busy, 0);
    @(negedge clkIn);
    resetIn = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clkIn);
      pulses += int'(acceptWrite) + int'(ramWrite) + int'(busy);
    end
    check("midwr no activity after reset", pulses, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // clearIn in IDLE: read request refused, write request accepted.
    @(negedge clkIn);
    clearIn = 1'b1; missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = 28'h0000012;
    @(negedge clkIn);
    check("idleclr read refused busy", busy, 0);
    readWriteIn = 1'b0; missAddrIn = 28'h0000034; writeBackIn = wb34;
    @(negedge clkIn);
    check("idleclr write busy", busy, 1);
    check("idleclr write ramWrite", ramWrite, 1);
    check("idleclr write ramAddr", ramAddr, 32'h340);
    clearIn = 1'b0; missIn = 1'b0;
    pulses = 0;
    for (int k = 2; k <= 19; k++) begin
      @(negedge clkIn);
      pulses += int'(acceptWrite);
      if (k == 17) check("idleclr acceptWrite k17", acceptWrite, 1);
    end
    check("idleclr pulse count", pulses, 1);

    // missIn held high across DONE: second write accepted only after IDLE.
    @(negedge clkIn);
    missIn = 1'b1; readWriteIn = 1'b0; missAddrIn = 28'h0000456; writeBackIn = wbx;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clkIn);
      pulses += int'(acceptWrite);
      if (k == 17) begin
        check("held DONE acceptWrite", acceptWrite, 1);
        check("held DONE ramWrite", ramWrite, 0);
      end
      if (k == 18) begin
        check("held IDLE busy", busy, 0);
        check("held IDLE ramWrite", ramWrite, 0);
        check("held IDLE acceptWrite", acceptWrite, 0);
      end
      if (k == 19) begin
        check("held 2nd busy", busy, 1);
        check("held 2nd ramWrite", ramWrite, 1);
        check("held 2nd ramAddr", ramAddr, 32'h4560);
        missIn = 1'b0;
      end
      if (k == 35) check("held 2nd acceptWrite", acceptWrite, 1);
    end
    check("held pulse count", pulses, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
- Sits directly downstream of the data cache, between its miss interface and the byte-wide external RAM port.
- Serialises whole-line fills (RAM -> cache) and whole-line write-backs (cache -> RAM) into per-byte RAM transactions.
- Returns the completed line, or a write acknowledgement, on the cache's refill interface.
- Handles one request at a time. A read in flight is abortable by the branch-mispredict clear; a write is not.

Parameters:
- BLOCK_WIDTH, 4, log2 of line size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes (16).

Ports:
- clkIn  in  1  system clock; all state updates on its rising edge.
- resetIn  in  1  asynchronous, active-high reset.
- clearIn  in  1  wrong-branch clear; aborts an in-flight line read.
- missIn  in  1  cache requests a line transfer.
- missAddrIn  in  [31:BLOCK_WIDTH]  line address of the request.
- readWriteIn  in  1  1 = line fill (read RAM), 0 = write-back (write RAM).
- writeBackIn  in  BLOCK_SIZE*8  line data to write; byte k is at bits [8k+7:8k].
- memDataValid  out  1  one-cycle pulse: memDataOut holds the filled line.
- memAddrOut  out  [31:BLOCK_WIDTH]  line address of the completed transfer.
- memDataOut  out  BLOCK_SIZE*8  filled line data.
- acceptWrite  out  1  one-cycle pulse: write-back of memAddrOut is complete.
- busy  out  1  high in every state other than IDLE.
- ramAddr  out  32  RAM byte address.
- ramWrite  out  1  1 = RAM write this cycle.
- ramDataOut  out  8  byte to write.
- ramDataIn  in  8  byte read; valid the cycle after its address is presented.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE and the counter to 0. All outputs are 0: memDataValid, acceptWrite, busy, ramWrite, ramAddr, ramDataOut, memAddrOut, memDataOut. Any in-flight transfer is dropped, with no pulse and no further RAM writes.
- States: IDLE, READ, WRITE, DONE. A 5-bit counter cnt is used by READ and WRITE.
- IDLE:
  - On an edge with missIn=1, latch missAddrIn as base, readWriteIn as rw, and writeBackIn as wdata; set cnt=0.
  - rw=1 goes to READ; rw=0 goes to WRITE.
  - In IDLE, ramWrite=0 and ramAddr=0.
- READ (17 cycles, cnt = 0..16):
  - While cnt<16: ramAddr={base,4'b0}+cnt and ramWrite=0.
  - At cnt=16: ramAddr is held at its last value.
  - On each edge with cnt>=1, store ramDataIn into line byte cnt-1.
  - On the edge at cnt=16: go to DONE and set memDataValid=1 and memAddrOut=base. Byte 15 lands in memDataOut on this same edge.
- WRITE (16 cycles, cnt = 0..15):
  - ramWrite=1, ramAddr={base,4'b0}+cnt, ramDataOut=wdata byte cnt.
  - On the edge at cnt=15: go to DONE and set acceptWrite=1 and memAddrOut=base.
- DONE (exactly 1 cycle):
  - The pulse output is high, memDataOut/memAddrOut are stable, and ramWrite=0.
  - missIn is ignored in this cycle, because the cache updates its line during it.
  - Next state is IDLE, with both pulses cleared.
- Latency from the request edge to the pulse cycle: read = 18 cycles, write = 17 cycles. A new request is accepted at the earliest on the first IDLE cycle after DONE.
- clearIn:
  - In READ: on the next edge go to IDLE, with no memDataValid and memDataOut unchanged.
  - In WRITE and DONE: ignored.
  - In IDLE with missIn=1: a read request is not accepted; a write request is accepted.
- Address arithmetic: a line never crosses its own 16-byte boundary. The low 4 bits are cnt[3:0]; no carry into base is possible.
- Inputs missAddrIn, readWriteIn and writeBackIn are sampled only at acceptance. Changes afterwards have no effect.

Test Plan:
- Reset mid-WRITE at cnt=5 -> same cycle: ramWrite=0 and busy=0; no acceptWrite ever follows; the next missIn is accepted normally.
- Fill of line 0x0000_0120: missIn=1, readWriteIn=1, missAddrIn=0x0000012, RAM model returns byte = addr[7:0] ->
  - ramAddr steps 0x120..0x12F with ramWrite=0;
  - memDataValid pulses exactly once, 18 cycles after the request edge;
  - memDataOut=0x2F2E...2120; memAddrOut=0x0000012.
- Write-back of line 0x0000_0340 with writeBackIn=0x0F0E...0100 ->
  - 16 consecutive cycles with ramWrite=1, ramAddr 0x340..0x34F, ramDataOut 0x00..0x0F;
  - acceptWrite pulses once, 17 cycles after the request edge.
- clearIn at READ cnt=7 -> IDLE on the next edge; memDataValid stays 0; a following fill of a different line completes with correct data.
- clearIn at WRITE cnt=3 -> ignored; all 16 bytes are written and acceptWrite pulses.
- missIn held high across DONE -> the second request is accepted only on the IDLE cycle after DONE; back-to-back transfers show no overlap and no duplicate pulse.
